// File: rtl/bcd_conv_pkg.sv
// Shared types, constants and sizing helpers for the sequential binary-to-BCD converter.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    // Width of a down-counter that must hold the value DATA_WIDTH.
    function automatic int cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

    // ceil(dw * log10(2)) using a fixed-point approximation of log10(2).
    function automatic int min_digits(input int dw);
        return (dw * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD) : digit_in;

endmodule

// File: rtl/alu_result_bcd_conv.sv
// Multi-cycle shift-and-add-3 converter from the ALU result word to BCD digits,
// with optional two's-complement sign handling and a leading-zero blanking mask.
module alu_result_bcd_conv
    import bcd_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int N_DIGITS   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    signed_mode,
    input  logic [DATA_WIDTH-1:0]   bin_in,
    output logic                    busy,
    output logic                    done,
    output logic                    negative,
    output logic [4*N_DIGITS-1:0]   bcd_out,
    output logic [N_DIGITS-1:0]     blank
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam int BW = 4 * N_DIGITS;
    localparam logic [N_DIGITS-1:0] BLANK_RESET = {{(N_DIGITS-1){1'b1}}, 1'b0};

    generate
        if (N_DIGITS < min_digits(DATA_WIDTH) || N_DIGITS < 2) begin : g_digits_check
            $error("alu_result_bcd_conv: N_DIGITS too small for DATA_WIDTH");
        end
    endgenerate

    conv_state_t            state_reg;
    logic [CW-1:0]          count_reg;
    logic [DATA_WIDTH-1:0]  mag_reg;
    logic [BW-1:0]          scratch_reg;
    logic                   neg_reg;

    logic                   bin_neg;
    logic [DATA_WIDTH-1:0]  mag_load;
    logic [BW-1:0]          adj;
    logic [BW-1:0]          scratch_next;
    logic [N_DIGITS-1:1]    digit_zero;
    logic [N_DIGITS-1:0]    blank_next;

    assign busy     = (state_reg != IDLE);
    assign bin_neg  = signed_mode & bin_in[DATA_WIDTH-1];
    assign mag_load = bin_neg ? (~bin_in + DATA_WIDTH'(1)) : bin_in;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit_in  (scratch_reg[4*gi +: 4]),
                .digit_out (adj[4*gi +: 4])
            );
        end
    endgenerate

    assign scratch_next = {adj[BW-2:0], mag_reg[DATA_WIDTH-1]};

    // A digit is blanked only when it and every more significant digit are zero.
    generate
        for (gi = 1; gi < N_DIGITS; gi++) begin : g_blank
            assign digit_zero[gi] = (scratch_next[4*gi +: 4] == 4'd0);
            assign blank_next[gi] = &digit_zero[N_DIGITS-1:gi];
        end
    endgenerate
    assign blank_next[0] = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            mag_reg     <= '0;
            scratch_reg <= '0;
            neg_reg     <= 1'b0;
            done        <= 1'b0;
            negative    <= 1'b0;
            bcd_out     <= '0;
            blank       <= BLANK_RESET;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mag_reg     <= mag_load;
                        neg_reg     <= bin_neg;
                        scratch_reg <= '0;
                        count_reg   <= CW'(DATA_WIDTH);
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // With enough digits the top digit never reaches 5, so nothing is shifted out.
                    assert (adj[BW-1] == 1'b0);
                    scratch_reg <= scratch_next;
                    mag_reg     <= mag_reg << 1;
                    count_reg   <= count_reg - CW'(1);
                    if (count_reg == CW'(1)) begin
                        bcd_out   <= scratch_next;
                        blank     <= blank_next;
                        negative  <= neg_reg;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_result_bcd_conv.md
Name: alu_result_bcd_conv

Overview:
Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) that consumes the ALU `result` word. It produces per-digit BCD and a leading-zero blanking mask for the `dig_displ_7_segs` decoders. It replaces the combinational divide/modulo digit extraction with a small multi-cycle datapath. Optional two's-complement interpretation gives sign plus magnitude.

Parameters:
DATA_WIDTH, 32, width of input word (ALU datapath width)
N_DIGITS, 10, number of BCD digits produced; must be >= ceil(DATA_WIDTH*log10(2)); elaboration-time assertion fails otherwise

Ports:
clk  input  1  system clock (MAX10_CLK1_50 at top level)
rst  input  1  asynchronous, active-high reset
start  input  1  request conversion of bin_in; accepted only in IDLE
signed_mode  input  1  1 = treat bin_in as two's complement; sampled with start
bin_in  input  DATA_WIDTH  value to convert (ALU result); sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; bcd_out/negative/blank valid from this cycle
negative  output  1  1 = input was negative (signed_mode only)
bcd_out  output  4*N_DIGITS  digit i at [4i+3:4i], digit 0 = units
blank  output  N_DIGITS  bit i = 1: digit i is a leading zero; bit 0 always 0

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, negative=0, bcd_out=0, blank={N_DIGITS-1 ones, 0}. A conversion in flight is discarded with no done.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE, start=1 at clock edge:
  - capture magnitude: if signed_mode && bin_in[DATA_WIDTH-1], mag = (~bin_in + 1) modulo 2^DATA_WIDTH, neg_r=1; else mag = bin_in, neg_r=0.
  - clear scratch BCD, load shift counter = DATA_WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - every scratch digit >= 5 gets +3 (4-bit, no carry across digits).
  - then shift {scratch, mag} left by 1 and decrement counter.
  - after the DATA_WIDTH-th shift: register bcd_out, negative, blank; go to DONE.
- DONE: done=1 for exactly this cycle; next state IDLE unconditionally.
- Latency: start high in cycle 0 -> done high in cycle DATA_WIDTH+1 (33 for default). Throughput is one conversion per DATA_WIDTH+2 cycles.
- start while busy=1, including the DONE cycle: ignored, not queued. bin_in and signed_mode are don't-care outside the accept cycle.
- Outputs hold their last converted value until the next DONE; they do not change during SHIFT.
- Magnitude -2^(DATA_WIDTH-1) (e.g. 0x80000000) gives mag 2^(DATA_WIDTH-1), negative=1. No overflow case exists.
- blank: bit i = 1 iff all digits i..N_DIGITS-1 are zero, i>=1; bit 0 forced 0, so a value of 0 displays "0".
- signed_mode=0: negative is always 0.

Decomposition:
- Package bcd_conv_pkg:
  - conv_state_t enum {IDLE, SHIFT, DONE}
  - BCD_ADJ_THRESH = 4'd5, BCD_ADJ_ADD = 4'd3
  - function to compute shift-counter width, $clog2(DATA_WIDTH+1)
- Sub-module bcd_digit_adj: combinational, 4-bit in/out, add 3 if >= 5. Instantiated N_DIGITS times in a generate loop.
- Blank-mask generation stays inline.

Test Plan:
1. Reset, then start with bin_in=32'd26, signed_mode=0 -> done in cycle 33. Digits 1..0 = 2,6, higher digits 0. blank=10'b1111111100, negative=0.
2. bin_in=0 -> bcd_out=0, blank=10'b1111111110. bin_in=32'hFFFFFFFF, signed_mode=0 -> digits 4294967295, blank=0.
3. signed_mode=1: bin_in=32'hFFFFFFFF -> negative=1, value 1, blank=10'b1111111110. bin_in=32'h80000000 -> negative=1, digits 2147483648.
4. Start pulses while busy (cycle 5) and in the DONE cycle -> ignored: exactly one done, outputs reflect the first operand only. Start in the cycle after DONE -> accepted.
5. Assert rst in cycle 10 of a conversion of 32'd999 -> busy/done/bcd_out/blank take reset values immediately. No done follows. A new conversion after release completes normally.
6. Random sweep (1000 values, both modes) -> bcd_out matches the decimal reference model. done is high exactly once per accepted start, always DATA_WIDTH+1 cycles after it.
